// File: rtl/logic_unit_arbiter.sv
// Round-robin shared 64-bit AND/OR/XOR/ANDN unit; accept in cycle N gives a registered result in N+1.
// One output stage: while the owner withholds resp_ready, both req_ready stay low (backpressure).
module logic_unit_arbiter #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAGW-1:0]  req0_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_s,
  output logic [TAGW-1:0]  resp0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAGW-1:0]  req1_tag,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_s,
  output logic [TAGW-1:0]  resp1_tag
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_grant, last_grant_nxt;
  logic [WIDTH-1:0] s_q, s_nxt;
  logic [TAGW-1:0]  tag_q, tag_nxt;
  logic             stage_free, gnt0, gnt1;

  function automatic logic [WIDTH-1:0] bitop(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   bitop = a & b;
      2'b01:   bitop = a | b;
      2'b10:   bitop = a ^ b;
      default: bitop = a & ~b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      s_q        <= '0;
      tag_q      <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      s_q        <= s_nxt;
      tag_q      <= tag_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    s_nxt          = s_q;
    tag_nxt        = tag_q;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    // A full stage still frees up when its owner drains it this cycle.
    stage_free = (state == EMPTY) || (owner ? resp1_ready : resp0_ready);

    if (stage_free) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end

    if (gnt0) begin
      state_nxt      = FULL;
      owner_nxt      = 1'b0;
      last_grant_nxt = 1'b0;
      s_nxt          = bitop(req0_op, req0_a, req0_b);
      tag_nxt        = req0_tag;
    end else if (gnt1) begin
      state_nxt      = FULL;
      owner_nxt      = 1'b1;
      last_grant_nxt = 1'b1;
      s_nxt          = bitop(req1_op, req1_a, req1_b);
      tag_nxt        = req1_tag;
    end else if (state == FULL && stage_free) begin
      state_nxt = EMPTY;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp0_valid = (state == FULL) && !owner;
  assign resp1_valid = (state == FULL) && owner;
  assign resp0_s     = s_q;
  assign resp1_s     = s_q;
  assign resp0_tag   = tag_q;
  assign resp1_tag   = tag_q;

endmodule
